// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// and the datapath select / ALU-op codes consumed by the ALU decoder.
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_LUI,
        S_JAL,
        S_ALUWB,
        S_BRANCH,
        S_FAULT
    } ctrl_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_FUNCT  = 2'b10,
        ALU_PASS_B = 2'b11
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // States that hold a memory request open and may stall on mem_ready_i.
    function automatic logic is_mem_wait_state(input ctrl_state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles of one memory request; hit_o flags the
// cycle in which the count would reach LIMIT.
module mem_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic hit_o
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // The stall in progress is the LIMIT-th one; the owner leaves the state
    // on this hit, which clears the counter before it can overflow.
    assign hit_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and drives datapath selects and strobes.
module multicycle_controller
    import core_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [6:0]  op_i,
    input  logic [2:0]  funct3_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        mem_valid_o,
    output logic        mem_write_o,
    output logic        adr_src_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        reg_write_o,
    output logic [1:0]  result_src_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output alu_op_t     alu_op_o,
    output imm_src_t    imm_src_o,
    output logic        retire_o,
    output logic        illegal_o,
    output logic        bus_error_o,
    output ctrl_state_t state_o
);

    ctrl_state_t state_q, state_d;
    logic        bus_error_q;
    logic        timer_hit;
    logic        timer_clear;
    logic        timer_en;

    logic mem_valid, mem_write, ir_write, pc_write, reg_write, retire, illegal;

    logic unused_funct3;
    assign unused_funct3 = ^funct3_i[2:1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_FETCH;
            bus_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_FAULT) begin
                bus_error_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_valid    = 1'b0;
        mem_write    = 1'b0;
        adr_src_o    = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        retire       = 1'b0;
        illegal      = 1'b0;
        result_src_o = RES_ALUOUT;
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_RD2;
        alu_op_o     = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                mem_valid    = 1'b1;
                alu_src_b_o  = SRCB_FOUR;
                result_src_o = RES_ALURESULT;
                if (mem_ready_i) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timer_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_IMM;
                case (op_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = SRCA_RD1;
                alu_src_b_o = SRCB_IMM;
                state_d     = op_i[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_valid = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_MEMWB;
                end else if (timer_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_MEMWB: begin
                result_src_o = RES_DATA;
                reg_write    = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_valid = 1'b1;
                mem_write = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (timer_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_EXECR: begin
                alu_src_a_o = SRCA_RD1;
                alu_src_b_o = SRCB_RD2;
                alu_op_o    = ALU_FUNCT;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_o = SRCA_RD1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALU_FUNCT;
                state_d     = S_ALUWB;
            end
            S_LUI: begin
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALU_PASS_B;
                state_d     = S_ALUWB;
            end
            S_JAL: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_FOUR;
                pc_write    = 1'b1;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o = SRCA_RD1;
                alu_src_b_o = SRCB_RD2;
                alu_op_o    = ALU_SUB;
                retire      = 1'b1;
                // funct3[0] flips the sense of zero: beq takes on equal, bne on unequal.
                pc_write    = zero_i ^ funct3_i[0];
                state_d     = S_FETCH;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    always_comb begin
        case (op_i)
            OP_STORE:  imm_src_o = IMM_S;
            OP_BRANCH: imm_src_o = IMM_B;
            OP_JAL:    imm_src_o = IMM_J;
            OP_LUI:    imm_src_o = IMM_U;
            default:   imm_src_o = IMM_I;
        endcase
    end

    assign timer_en    = is_mem_wait_state(state_q) && !mem_ready_i;
    assign timer_clear = mem_ready_i || (state_d != state_q);

    mem_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_mem_wait_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (timer_clear),
        .en_i    (timer_en),
        .hit_o   (timer_hit)
    );

    // Reset state is FETCH, so strobes are masked while reset is held.
    assign mem_valid_o = mem_valid & rst_ni;
    assign mem_write_o = mem_write & rst_ni;
    assign ir_write_o  = ir_write  & rst_ni;
    assign pc_write_o  = pc_write  & rst_ni;
    assign reg_write_o = reg_write & rst_ni;
    assign retire_o    = retire    & rst_ni;
    assign illegal_o   = illegal   & rst_ni;
    assign bus_error_o = bus_error_q;
    assign state_o     = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM of the multicycle RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath mux selects and write strobes, and produces the 2-bit alu_op that feeds the downstream ALU decoder.
- Holds in memory states until the unified instruction/data memory signals ready. A wait-timeout raises a sticky bus error.

Parameters:
- TIMEOUT_CYCLES, 255: maximum consecutive wait cycles on one memory request before FAULT. Minimum 1. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- op_i  in  7  instruction opcode, from the instruction register
- funct3_i  in  3  instruction funct3 (branch polarity)
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory completed the current request this cycle
- mem_valid_o  out  1  memory request active
- mem_write_o  out  1  request is a store
- adr_src_o  out  1  0 = PC, 1 = ALUOut
- ir_write_o  out  1  load instruction register (and OldPC)
- pc_write_o  out  1  load PC
- reg_write_o  out  1  register-file write enable
- result_src_o  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a_o  out  2  00 = PC, 01 = OldPC, 10 = rd1
- alu_src_b_o  out  2  00 = rd2, 01 = ImmExt, 10 = constant 4
- alu_op_o  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded, 11 = pass B (lui)
- imm_src_o  out  3  I = 000, S = 001, B = 010, J = 011, U = 100; combinational from op_i
- retire_o  out  1  one-cycle pulse when an instruction completes
- illegal_o  out  1  one-cycle pulse on an unsupported opcode
- bus_error_o  out  1  sticky, set on memory timeout

Behaviour:
- Reset
  - Async on rst_ni low: state = FETCH, wait counter = 0, bus_error_o = 0.
  - While in reset, all strobes are 0: mem_valid_o, mem_write_o, ir_write_o, pc_write_o, reg_write_o, retire_o, illegal_o.
  - Selects and alu_op_o take their FETCH values.
- Output style: Moore outputs decoded from the registered state. Exceptions: pc_write_o, ir_write_o and retire_o also depend on mem_ready_i and zero_i.
- FETCH
  - mem_valid=1, adr_src=0, srcA=00, srcB=10, alu_op=00, result_src=10.
  - On mem_ready_i: ir_write=1 and pc_write=1 in the same cycle, then go to DECODE. Otherwise hold.
- DECODE
  - srcA=01, srcB=01, alu_op=00 (computes the branch/jump target into ALUOut).
  - Next state by op_i:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 0110111 -> LUI
    - any other opcode -> illegal_o=1 for this cycle, then FETCH.
- MEMADR: srcA=10, srcB=01, alu_op=00. Go to MEMREAD if op_i[5]=0, otherwise MEMWRITE.
- MEMREAD: mem_valid=1, adr_src=1. On ready -> MEMWB.
- MEMWB: result_src=01, reg_write=1, retire=1. Then FETCH.
- MEMWRITE: mem_valid=1, mem_write=1, adr_src=1. On ready: retire=1, then FETCH.
- EXECR: srcA=10, srcB=00, alu_op=10. Then ALUWB.
- EXECI: srcA=10, srcB=01, alu_op=10. Then ALUWB.
- LUI: srcB=01, alu_op=11. Then ALUWB.
- JAL: srcA=01, srcB=10, alu_op=00, result_src=00, pc_write=1. Then ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1. Then FETCH.
- BRANCH
  - srcA=10, srcB=00, alu_op=01, result_src=00, retire=1. Then FETCH.
  - pc_write = zero_i XOR funct3_i[0] (beq/bne).
- Wait counter
  - Increments each cycle the FSM is in FETCH, MEMREAD or MEMWRITE with mem_ready_i=0.
  - Clears on ready and on any state change.
  - When the counter reaches TIMEOUT_CYCLES with mem_ready_i still 0: go to FAULT and set bus_error_o=1.
  - mem_ready_i on the same cycle the counter reaches the limit wins: normal transition, no fault.
- FAULT: all strobes 0, alu_op=00. Held until reset.
- Each instruction takes at least 3 cycles. Minimum latency: ALU ops 4, loads 5, stores 4, branches 3, jal 4.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - ctrl_state_t enum
  - opcode constants
  - alu_op and imm_src encodings, typed and shared with the ALU decoder
  - result_src, alu_src_a and alu_src_b encodings
- One sub-module, mem_wait_timer: counter with clear, enable and limit-hit output.
- imm_src decode stays inline as combinational logic.

Test Plan:
- Reset then `add` (op 0110011), ready asserted every request -> states FETCH, DECODE, EXECR, ALUWB; alu_op 10 in EXECR; reg_write and retire in cycle 4; pc_write exactly once.
- `lw` with mem_ready_i low for 3 cycles in MEMREAD -> FSM holds MEMREAD for 3 cycles; MEMWB one cycle after ready; total latency 8 cycles.
- `beq` with zero_i=1 -> pc_write=1 in BRANCH; `bne` (funct3=001) with zero_i=1 -> pc_write=0; both pulse retire.
- `lui` (0110111) -> alu_op 11, imm_src 100; reg_write one cycle later.
- Opcode 1110011 -> illegal_o pulses once in DECODE; next state FETCH; reg_write is never asserted.
- TIMEOUT_CYCLES=4, mem_ready_i held low in FETCH -> FAULT after 4 wait cycles; bus_error_o=1 and stays 1 under later ready; rst_ni low mid-FAULT clears it asynchronously.
